// File: rtl/test_supervisor.sv
// test_supervisor: sequences DUT reset, aggregates per-channel pass/fail, enforces a
// cycle-budget watchdog and produces a waveform-dump window. Rev 1.0
`default_nettype none

module test_supervisor #(
    parameter int N_CHANNELS   = 4,
    parameter int CYCLE_W      = 64,
    parameter int RESET_CYCLES = 8,
    parameter int CH_W         = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CYCLE_W-1:0]    max_cycles,
    input  logic [CYCLE_W-1:0]    dump_start,
    input  logic [CYCLE_W-1:0]    dump_stop,
    input  logic [N_CHANNELS-1:0] chan_mask,
    input  logic [N_CHANNELS-1:0] chan_success,
    input  logic [N_CHANNELS-1:0] chan_failure,
    output logic                  dut_reset,
    output logic [CYCLE_W-1:0]    cycle_count,
    output logic                  dump_en,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [1:0]            fail_reason,
    output logic [CH_W-1:0]       fail_chan
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    localparam logic [1:0] R_NONE  = 2'd0;
    localparam logic [1:0] R_CHAN  = 2'd1;
    localparam logic [1:0] R_TIME  = 2'd2;
    localparam logic [1:0] R_EMPTY = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [CYCLE_W-1:0]    cycle_count_q, cycle_count_d;
    logic [N_CHANNELS-1:0] succ_flag_q, succ_flag_d;
    logic                  dut_reset_q, dut_reset_d;
    logic                  dump_en_q, dump_en_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic [1:0]            fail_reason_q, fail_reason_d;
    logic [CH_W-1:0]       fail_chan_q, fail_chan_d;

    logic [N_CHANNELS-1:0] succ_hits;
    logic [N_CHANNELS-1:0] fail_hits;
    logic [CH_W-1:0]       fail_idx;

    assign succ_hits = chan_success & chan_mask;
    assign fail_hits = chan_failure & chan_mask;

    // Descending scan so the lowest-index failing channel is the one that sticks.
    always_comb begin
        fail_idx = '0;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (fail_hits[i]) begin
                fail_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        succ_flag_d   = succ_flag_q;
        dut_reset_d   = dut_reset_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        fail_reason_d = fail_reason_q;
        fail_chan_d   = fail_chan_q;
        cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;

        case (state_q)
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = S_RUN;
                    dut_reset_d = 1'b0;
                end
            end
            S_RUN: begin
                succ_flag_d = succ_flag_q | succ_hits;
                if (chan_mask == '0) begin
                    state_d       = S_FAIL;
                    done_d        = 1'b1;
                    fail_d        = 1'b1;
                    fail_reason_d = R_EMPTY;
                end else if (|fail_hits) begin
                    state_d       = S_FAIL;
                    done_d        = 1'b1;
                    fail_d        = 1'b1;
                    fail_reason_d = R_CHAN;
                    fail_chan_d   = fail_idx;
                end else if ((max_cycles != '0) && (cycle_count_q > max_cycles)) begin
                    state_d       = S_FAIL;
                    done_d        = 1'b1;
                    fail_d        = 1'b1;
                    fail_reason_d = R_TIME;
                end else if ((succ_flag_d & chan_mask) == chan_mask) begin
                    state_d       = S_PASS;
                    done_d        = 1'b1;
                    pass_d        = 1'b1;
                    fail_reason_d = R_NONE;
                end
            end
            default: begin
            end
        endcase

        // Uses the current state, so the window closes one edge after done rises.
        dump_en_d = (cycle_count_d >= dump_start)
                  && ((dump_stop == '0) || (cycle_count_d < dump_stop))
                  && ((state_q == S_HOLD) || (state_q == S_RUN));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            succ_flag_q   <= '0;
            dut_reset_q   <= 1'b1;
            dump_en_q     <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_reason_q <= R_NONE;
            fail_chan_q   <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
            succ_flag_q   <= succ_flag_d;
            dut_reset_q   <= dut_reset_d;
            dump_en_q     <= dump_en_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            fail_reason_q <= fail_reason_d;
            fail_chan_q   <= fail_chan_d;
        end
    end

    assign dut_reset   = dut_reset_q;
    assign cycle_count = cycle_count_q;
    assign dump_en     = dump_en_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_reason = fail_reason_q;
    assign fail_chan   = fail_chan_q;

endmodule

`default_nettype wire
